bram_frame_streamer: RTL and testbench

Parametrised BRAM-to-AXI-Stream reader for the lattice output path. On a frame start it sweeps `DEPTH` BRAM addresses and packs `CHANNELS` direction values per node into one AXIS beat. It tolerates BRAM read latency and arbitrary `tready` backpressure without dropping or duplicating nodes, and marks frame and row boundaries. It sits between the lattice result BRAMs and the DMA-facing `m00_axis` master.

---
 rtl/bram_frame_streamer_if.sv | 27 ++
 rtl/bram_frame_streamer.sv | 150 +++++++++++++++
 tb/tb_bram_frame_streamer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_frame_streamer_if.sv
// ----------------------------------------------------------------------------
// bram_frame_streamer_if
// AXI4-Stream bundle for the lattice output path.
//   tvalid/tdata/tstrb/tlast/tuser : master -> slave
//   tready                         : slave  -> master
// TDATA_WIDTH must be a multiple of 8; tstrb carries one bit per byte.
// ----------------------------------------------------------------------------
interface bram_frame_streamer_if #(
    parameter int unsigned TDATA_WIDTH = 144
);
    logic                     tvalid;
    logic                     tready;
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tstrb;
    logic                     tlast;
    logic                     tuser;

    modport master (
        output tvalid, tdata, tstrb, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/bram_frame_streamer.sv
// ----------------------------------------------------------------------------
// bram_frame_streamer
// Sweeps DEPTH BRAM addresses per frame and streams one node (CHANNELS packed
// direction values) per AXIS beat. A credit-limited issue side plus a small
// return FIFO absorbs BRAM read latency and arbitrary tready backpressure.
//
// Ports:
//   m00_axis_aclk    sole clock
//   m00_axis_areset  synchronous active-high reset
//   frame_ready      frame start request, only honoured while idle
//   busy             frame in progress (accept edge .. final beat handshake)
//   frame_done       one-cycle pulse after the final beat handshake
//   read_en          BRAM read strobe
//   read_addr        BRAM read address (holds while read_en is low)
//   rd_data          BRAM read data, channel 0 in the LSBs
//   m00_axis         AXIS master (tuser = first node, tlast = frame/row end)
// ----------------------------------------------------------------------------
module bram_frame_streamer #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned CHANNELS      = 9,
    parameter int unsigned DEPTH         = 2500,
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned ROW_LEN       = 50,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned TLAST_MODE    = 0
) (
    input  logic                           m00_axis_aclk,
    input  logic                           m00_axis_areset,
    input  logic                           frame_ready,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           read_en,
    output logic [ADDRESS_WIDTH-1:0]       read_addr,
    input  logic [CHANNELS*DATA_WIDTH-1:0] rd_data,
    bram_frame_streamer_if.master          m00_axis
);
    localparam int unsigned TDATA_WIDTH = CHANNELS * DATA_WIDTH;
    localparam int unsigned FIFO_DEPTH  = READ_LATENCY + 2;
    localparam int unsigned PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_WIDTH   = $clog2(FIFO_DEPTH + 1);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_NODE = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_COL  = ADDRESS_WIDTH'(ROW_LEN - 1);
    localparam logic [PTR_WIDTH-1:0]     LAST_SLOT = PTR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [OCC_WIDTH-1:0]     CREDITS   = OCC_WIDTH'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] issue_cnt;
    logic [ADDRESS_WIDTH-1:0] send_cnt;
    logic [ADDRESS_WIDTH-1:0] row_cnt;
    logic [READ_LATENCY-1:0]  tag_sr;
    logic [TDATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]     wr_ptr, rd_ptr;
    logic [OCC_WIDTH-1:0]     fifo_count;
    logic [OCC_WIDTH-1:0]     in_flight;

    logic accept, fifo_empty, push, pop, last_issue, last_beat;

    // Reads still travelling through the BRAM pipeline each hold a FIFO slot.
    always_comb begin
        in_flight = '0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            in_flight = in_flight + OCC_WIDTH'(tag_sr[i]);
        end
    end

    assign accept     = (state_q == IDLE) && frame_ready;
    assign fifo_empty = (fifo_count == '0);
    assign push       = tag_sr[READ_LATENCY-1];
    assign pop        = m00_axis.tvalid && m00_axis.tready;
    assign read_en    = (state_q == STREAM) && ((fifo_count + in_flight) < CREDITS);
    assign read_addr  = issue_cnt;
    assign last_issue = read_en && (issue_cnt == LAST_NODE);
    assign last_beat  = pop && (send_cnt == LAST_NODE);
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (frame_ready) state_d = STREAM;
            STREAM:  if (last_issue)  state_d = FLUSH;
            FLUSH:   if (last_beat)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            state_q    <= IDLE;
            frame_done <= 1'b0;
            issue_cnt  <= '0;
            send_cnt   <= '0;
            row_cnt    <= '0;
            tag_sr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state_q    <= state_d;
            frame_done <= last_beat;
            tag_sr     <= (tag_sr << 1) | READ_LATENCY'(read_en);

            // Counters park on the last node so they never wrap mid-frame.
            if (accept) begin
                issue_cnt <= '0;
                send_cnt  <= '0;
                row_cnt   <= '0;
            end else begin
                if (read_en && !last_issue) issue_cnt <= issue_cnt + ADDRESS_WIDTH'(1);
                if (pop && !last_beat)      send_cnt  <= send_cnt + ADDRESS_WIDTH'(1);
                if (pop) row_cnt <= (row_cnt == LAST_COL) ? '0 : row_cnt + ADDRESS_WIDTH'(1);
            end

            if (push) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PTR_WIDTH'(1);
            if (pop)  rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + PTR_WIDTH'(1);

            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + OCC_WIDTH'(1);
                2'b01:   fifo_count <= fifo_count - OCC_WIDTH'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: the output mux masks it while the FIFO is empty.
    always_ff @(posedge m00_axis_aclk) begin
        if (push) fifo_mem[wr_ptr] <= rd_data;
    end

    // The credit check on read_en must make a push into a full FIFO impossible.
    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_areset) begin
            assert (!(push && !pop && (fifo_count == CREDITS)));
        end
    end

    always_comb begin
        m00_axis.tvalid = !fifo_empty;
        m00_axis.tdata  = fifo_empty ? '0 : fifo_mem[rd_ptr];
        m00_axis.tstrb  = '1;
        m00_axis.tuser  = !fifo_empty && (send_cnt == '0);
        if (TLAST_MODE == 1) begin
            m00_axis.tlast = !fifo_empty && (row_cnt == LAST_COL);
        end else begin
            m00_axis.tlast = !fifo_empty && (send_cnt == LAST_NODE);
        end
    end
endmodule

// File: tb/tb_bram_frame_streamer.sv
// ----------------------------------------------------------------------------
// tb_bram_frame_streamer
// Two streamer instances share one BRAM image:
//   dut_a : READ_LATENCY=1, tlast at end of frame
//   dut_b : READ_LATENCY=2, tlast at end of every row
// The reference model states what beat k must look like (data = mem[k],
// tuser = k==0, tlast from k by modulo arithmetic) and when events occur.
// Cycle index n counts rising edges after the accepting edge (n=0 is the
// cycle following acceptance; the frame_ready cycle is n=-1).
// ----------------------------------------------------------------------------
module tb_bram_frame_streamer;
    localparam int unsigned DW    = 16;
    localparam int unsigned CH    = 9;
    localparam int unsigned TW    = DW * CH;
    localparam int unsigned DEPTH = 2500;
    localparam int unsigned AW    = 12;
    localparam int unsigned ROW   = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int sel   = 0;
    logic fr_drv   = 1'b0;
    logic trdy_drv = 1'b0;

    logic [TW-1:0] mem [DEPTH];

    logic          fr_a, fr_b, busy_a, busy_b, done_a, done_b, re_a, re_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [TW-1:0] rd_a, rd_b, qa1, qb1, qb2;

    bram_frame_streamer_if #(.TDATA_WIDTH(TW)) axa ();
    bram_frame_streamer_if #(.TDATA_WIDTH(TW)) axb ();

    assign fr_a       = (sel == 0) && fr_drv;
    assign fr_b       = (sel == 1) && fr_drv;
    assign axa.tready = (sel == 0) && trdy_drv;
    assign axb.tready = (sel == 1) && trdy_drv;

    // BRAM models: registered read, plus an output register for latency 2.
    always @(posedge clk) begin
        if (re_a) qa1 <= mem[addr_a];
        if (re_b) qb1 <= mem[addr_b];
        qb2 <= qb1;
    end
    assign rd_a = qa1;
    assign rd_b = qb2;

    bram_frame_streamer #(
        .DATA_WIDTH(DW), .CHANNELS(CH), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW),
        .ROW_LEN(ROW), .READ_LATENCY(1), .TLAST_MODE(0)
    ) dut_a (
        .m00_axis_aclk(clk), .m00_axis_areset(rst), .frame_ready(fr_a),
        .busy(busy_a), .frame_done(done_a), .read_en(re_a), .read_addr(addr_a),
        .rd_data(rd_a), .m00_axis(axa)
    );

    bram_frame_streamer #(
        .DATA_WIDTH(DW), .CHANNELS(CH), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW),
        .ROW_LEN(ROW), .READ_LATENCY(2), .TLAST_MODE(1)
    ) dut_b (
        .m00_axis_aclk(clk), .m00_axis_areset(rst), .frame_ready(fr_b),
        .busy(busy_b), .frame_done(done_b), .read_en(re_b), .read_addr(addr_b),
        .rd_data(rd_b), .m00_axis(axb)
    );

    // Observation mux onto the selected instance.
    logic            o_busy, o_done, o_re, o_tvalid, o_tlast, o_tuser;
    logic [AW-1:0]   o_addr;
    logic [TW-1:0]   o_tdata;
    logic [TW/8-1:0] o_tstrb;
    int              o_occ;
    always_comb begin
        if (sel == 0) begin
            o_busy = busy_a; o_done = done_a; o_re = re_a; o_addr = addr_a;
            o_tvalid = axa.tvalid; o_tlast = axa.tlast; o_tuser = axa.tuser;
            o_tdata = axa.tdata; o_tstrb = axa.tstrb; o_occ = int'(dut_a.fifo_count);
        end else begin
            o_busy = busy_b; o_done = done_b; o_re = re_b; o_addr = addr_b;
            o_tvalid = axb.tvalid; o_tlast = axb.tlast; o_tuser = axb.tuser;
            o_tdata = axb.tdata; o_tstrb = axb.tstrb; o_occ = int'(dut_b.fifo_count);
        end
    end

    task automatic fill_index();
        for (int i = 0; i < int'(DEPTH); i++)
            for (int c = 0; c < int'(CH); c++) mem[i][c*DW +: DW] = DW'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < int'(DEPTH); i++)
            for (int c = 0; c < int'(CH); c++) mem[i][c*DW +: DW] = DW'($urandom);
    endtask

    // One frame on the selected instance. duty = tready percentage, stall0 =
    // cycles of forced tready=0 after acceptance, poke_at = beat index at which
    // a stray frame_ready is pulsed, stop_at = beat index at which reset hits.
    task automatic stream(input int duty, input int stall0, input int poke_at, input int stop_at);
        int lat, mode, n, k, issued, tl_cnt, max_occ, acc, exp_tl;
        bit finished, seen_first, prev_stall, poked;
        logic [TW-1:0] prev_data, exp_data;
        logic exp_user, exp_last;
        lat = (sel == 0) ? 1 : 2;
        mode = (sel == 0) ? 0 : 1;
        k = 0; issued = 0; tl_cnt = 0; max_occ = 0;
        finished = 0; seen_first = 0; prev_stall = 0; poked = 0;
        prev_data = '0;
        fr_drv = 1'b1;
        trdy_drv = 1'b0;
        @(negedge clk);
        fr_drv = 1'b0;
        acc = cyc;
        n_vec++;
        if (o_busy !== 1'b1) begin
            n_err++; $display("FAIL busy_rise sel=%0d got=%b want=1", sel, o_busy);
        end
        for (int t = 0; t < 20000 && !finished; t++) begin
            n = cyc - acc;
            if (o_done === 1'b1) begin
                finished = 1;
                n_vec++;
                if (k != int'(DEPTH)) begin
                    n_err++; $display("FAIL done_beats sel=%0d got=%0d want=%0d", sel, k, DEPTH);
                end
                if (duty == 100 && stall0 == 0) begin
                    n_vec++;
                    if (n != int'(DEPTH) + lat + 1) begin
                        n_err++; $display("FAIL done_latency sel=%0d got=%0d want=%0d", sel, n, int'(DEPTH) + lat + 1);
                    end
                end
            end else begin
                if (stall0 > 0 && n == stall0) begin
                    n_vec++;
                    if (issued != lat + 2) begin
                        n_err++; $display("FAIL stall_reads sel=%0d got=%0d want=%0d", sel, issued, lat + 2);
                    end
                end
                if (o_re === 1'b1) begin
                    n_vec++;
                    if (o_addr !== AW'(issued)) begin
                        n_err++; $display("FAIL read_addr sel=%0d got=%0d want=%0d", sel, o_addr, issued);
                    end
                    issued++;
                end
                if (o_occ > max_occ) max_occ = o_occ;
                if (prev_stall) begin
                    n_vec++;
                    if (o_tvalid !== 1'b1 || o_tdata !== prev_data) begin
                        n_err++; $display("FAIL stall_hold sel=%0d beat=%0d got_valid=%b want_valid=1", sel, k, o_tvalid);
                    end
                end
                if (o_tvalid === 1'b1) begin
                    if (!seen_first) begin
                        seen_first = 1;
                        n_vec++;
                        if (n != lat + 1) begin
                            n_err++; $display("FAIL first_latency sel=%0d got=%0d want=%0d", sel, n, lat + 1);
                        end
                    end
                    n_vec++;
                    if (k >= int'(DEPTH)) begin
                        n_err++; $display("FAIL extra_beat sel=%0d got=%0d want<%0d", sel, k, DEPTH);
                    end else begin
                        exp_data = mem[k];
                        exp_user = (k == 0);
                        exp_last = (mode == 1) ? ((k % int'(ROW)) == int'(ROW) - 1) : (k == int'(DEPTH) - 1);
                        if ({o_tdata, o_tuser, o_tlast} !== {exp_data, exp_user, exp_last}) begin
                            n_err++;
                            $display("FAIL beat sel=%0d k=%0d got data=%h user=%b last=%b want data=%h user=%b last=%b",
                                     sel, k, o_tdata, o_tuser, o_tlast, exp_data, exp_user, exp_last);
                        end
                    end
                end
                if (stop_at >= 0 && k == stop_at && o_tvalid === 1'b1) begin
                    trdy_drv = 1'b0;
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    n_vec++;
                    if ({o_tvalid, o_busy, o_re, o_tlast, o_tuser} !== 5'b0) begin
                        n_err++; $display("FAIL midframe_reset sel=%0d got=%b want=00000", sel,
                                          {o_tvalid, o_busy, o_re, o_tlast, o_tuser});
                    end
                    @(negedge clk);
                    n_vec++;
                    if ({o_done, o_busy} !== 2'b0) begin
                        n_err++; $display("FAIL abandon_quiet sel=%0d got=%b want=00", sel, {o_done, o_busy});
                    end
                    return;
                end
                trdy_drv = (n < stall0) ? 1'b0 : ($urandom_range(99) < duty);
                prev_stall = o_tvalid && !trdy_drv;
                prev_data = o_tdata;
                if (o_tvalid && trdy_drv) begin
                    if (o_tlast) tl_cnt++;
                    k++;
                end
                fr_drv = 1'b0;
                if (poke_at >= 0 && !poked && k == poke_at) begin
                    fr_drv = 1'b1;
                    poked = 1;
                end
                @(negedge clk);
            end
        end
        fr_drv = 1'b0;
        n_vec++;
        if (!finished) begin
            n_err++; $display("FAIL frame_timeout sel=%0d got_beats=%0d want=%0d", sel, k, DEPTH);
        end
        exp_tl = (mode == 1) ? int'(DEPTH / ROW) : 1;
        n_vec++;
        if (tl_cnt != exp_tl) begin
            n_err++; $display("FAIL tlast_count sel=%0d got=%0d want=%0d", sel, tl_cnt, exp_tl);
        end
        n_vec++;
        if (max_occ > lat + 2) begin
            n_err++; $display("FAIL fifo_occupancy sel=%0d got=%0d want<=%0d", sel, max_occ, lat + 2);
        end
        @(negedge clk);
        n_vec++;
        if ({o_done, o_busy, o_tvalid} !== 3'b0) begin
            n_err++; $display("FAIL after_frame sel=%0d got=%b want=000", sel, {o_done, o_busy, o_tvalid});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            n_vec++;
            if ({o_busy, o_done, o_re, o_tvalid, o_tlast, o_tuser} !== 6'b0) begin
                n_err++; $display("FAIL reset_flags sel=%0d got=%b want=000000", s,
                                  {o_busy, o_done, o_re, o_tvalid, o_tlast, o_tuser});
            end
            n_vec++;
            if (o_addr !== '0) begin
                n_err++; $display("FAIL reset_addr sel=%0d got=%0d want=0", s, o_addr);
            end
            n_vec++;
            if (o_tdata !== '0) begin
                n_err++; $display("FAIL reset_tdata sel=%0d got=%h want=0", s, o_tdata);
            end
            n_vec++;
            if (o_tstrb !== '1) begin
                n_err++; $display("FAIL reset_tstrb sel=%0d got=%h want=all ones", s, o_tstrb);
            end
        end
        sel = 0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy_a, busy_b, re_a, re_b} !== 4'b0) begin
            n_err++; $display("FAIL idle_after_reset got=%b want=0000", {busy_a, busy_b, re_a, re_b});
        end
    endtask

    task automatic test_nominal();
        fill_index();
        sel = 0;
        stream(100, 0, -1, -1);
    endtask

    task automatic test_backpressure();
        fill_random();
        sel = 1;
        stream(30, 0, -1, -1);
    endtask

    task automatic test_row_mode();
        fill_random();
        sel = 1;
        stream(100, 0, -1, -1);
    endtask

    task automatic test_restart_ignored();
        fill_random();
        sel = 0;
        stream(100, 0, 1000, -1);
        stream(100, 0, -1, -1);
    endtask

    task automatic test_reset_midframe();
        fill_random();
        sel = 0;
        stream(60, 0, -1, 700);
        stream(100, 0, -1, -1);
    endtask

    task automatic test_long_stall();
        fill_random();
        sel = 0;
        stream(100, 100, -1, -1);
        sel = 1;
        stream(80, 100, -1, -1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_nominal();
        test_backpressure();
        test_row_mode();
        test_restart_ignored();
        test_reset_midframe();
        test_long_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
